// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI host: state encoding, frame and CRC7
// constants, common command indices and a single-bit CRC7 step.
package sd_spi_pkg;

  localparam int         FRAME_BITS = 48;
  localparam logic [6:0] CRC7_POLY  = 7'h09;  // x^7 + x^3 + 1

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_FRAME,
    ST_CRC,
    ST_END,
    ST_DONE
  } sd_state_e;

  // One serial CRC7 step: feedback is the incoming bit xor the register MSB.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_send_if.sv
// Request/serial-out bundle between the host controller and the command stage.
interface sd_cmd_send_if;
  logic        start;
  logic [5:0]  cmdIndex;
  logic [31:0] argument;
  logic        bitOut;
  logic        busy;
  logic        finish;

  modport master (output start, cmdIndex, argument, input bitOut, busy, finish);
  modport slave  (input start, cmdIndex, argument, output bitOut, busy, finish);
endinterface

// File: rtl/sd_crc7_serial.sv
// Serial CRC7 register. clr wins over en, en (accumulate a bit) wins over
// shift (emit MSB first, zero fill). Also usable for response CRC checking.
module sd_crc7_serial
  import sd_spi_pkg::*;
(
  input  logic spiClock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic shift,
  input  logic din,
  output logic dout
);

  logic [6:0] crc_q;

  // CRC register: clear, accumulate or shift out
  always_ff @(posedge spiClock or posedge reset) begin
    if (reset)      crc_q <= '0;
    else if (clr)   crc_q <= '0;
    else if (en)    crc_q <= crc7_step(crc_q, din);
    else if (shift) crc_q <= {crc_q[5:0], 1'b0};
  end

  assign dout = crc_q[6];

endmodule

// File: rtl/sd_cmd_send.sv
// SD command transmitter: optional idle-high preamble, then the 48-bit frame
// {0,1,index,argument,crc7,1} shifted MSB-first with CRC7 built on the fly.
// Level-held start/finish handshake matches the response read stage.
module sd_cmd_send
  import sd_spi_pkg::*;
#(
  parameter int PRE_BITS  = 8,
  parameter int CNT_WIDTH = 6
) (
  input  logic          spiClock,
  input  logic          reset,
  sd_cmd_send_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] PRE_LOAD   = CNT_WIDTH'((PRE_BITS > 0) ? PRE_BITS - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] FRAME_LOAD = CNT_WIDTH'(FRAME_BITS - 9);  // 40 header/arg bits
  localparam logic [CNT_WIDTH-1:0] CRC_LOAD   = CNT_WIDTH'(6);
  // END holds two edges: one drives the end bit, the next raises finish.
  localparam logic [CNT_WIDTH-1:0] END_LOAD   = CNT_WIDTH'(1);

  sd_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [39:0]           frame_q, frame_d;
  logic                  bit_q, bit_d;
  logic                  busy_q, busy_d;
  logic                  fin_q, fin_d;
  logic                  crc_clr, crc_en, crc_shift, crc_msb;
  logic                  abort;

  sd_crc7_serial u_crc (
    .spiClock (spiClock),
    .reset    (reset),
    .clr      (crc_clr),
    .en       (crc_en),
    .shift    (crc_shift),
    .din      (frame_q[39]),
    .dout     (crc_msb)
  );

  // State and datapath registers
  always_ff @(posedge spiClock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      bit_q   <= 1'b1;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  assign abort = !bus.start &&
                 (state_q inside {ST_PRE, ST_FRAME, ST_CRC, ST_END});

  // Next-state, counter, shifter and CRC control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    bit_d     = bit_q;
    busy_d    = busy_q;
    fin_d     = fin_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    crc_shift = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bit_d = 1'b1;
        if (bus.start) begin
          frame_d = {1'b0, 1'b1, bus.cmdIndex, bus.argument};
          crc_clr = 1'b1;
          busy_d  = 1'b1;
          if (PRE_BITS > 0) begin
            state_d = ST_PRE;
            cnt_d   = PRE_LOAD;
          end else begin
            state_d = ST_FRAME;
            cnt_d   = FRAME_LOAD;
          end
        end
      end
      ST_PRE: begin
        bit_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_FRAME;
          cnt_d   = FRAME_LOAD;
        end else cnt_d = cnt_q - CNT_WIDTH'(1);
      end
      ST_FRAME: begin
        bit_d   = frame_q[39];
        frame_d = {frame_q[38:0], 1'b0};
        crc_en  = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_CRC;
          cnt_d   = CRC_LOAD;
        end else cnt_d = cnt_q - CNT_WIDTH'(1);
      end
      ST_CRC: begin
        bit_d     = crc_msb;
        crc_shift = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_END;
          cnt_d   = END_LOAD;
        end else cnt_d = cnt_q - CNT_WIDTH'(1);
      end
      ST_END: begin
        bit_d = 1'b1;
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          fin_d   = 1'b1;
          state_d = ST_DONE;
        end else cnt_d = cnt_q - CNT_WIDTH'(1);
      end
      ST_DONE: begin
        bit_d = 1'b1;
        if (!bus.start) begin
          fin_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Host dropped start mid-command: back to idle with the line high.
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      bit_d   = 1'b1;
      busy_d  = 1'b0;
      fin_d   = 1'b0;
    end
  end

  assign bus.bitOut = bit_q;
  assign bus.busy   = busy_q;
  assign bus.finish = fin_q;

endmodule

// File: tb/tb_sd_cmd_send.sv
// Bench for sd_cmd_send: table of known SD command frames (CRC bytes are the
// published values), scoreboard queue of expected frames, plus handshake,
// abort and async-reset sequences. Two builds: PRE_BITS=8 and PRE_BITS=0.
module tb_sd_cmd_send;
  import sd_spi_pkg::*;

  logic spiClock = 1'b0;
  logic reset;
  always #5 spiClock = ~spiClock;

  sd_cmd_send_if bus0 ();
  sd_cmd_send_if bus1 ();

  sd_cmd_send #(.PRE_BITS(8), .CNT_WIDTH(6)) dut0 (
    .spiClock (spiClock), .reset (reset), .bus (bus0));
  sd_cmd_send #(.PRE_BITS(0), .CNT_WIDTH(6)) dut1 (
    .spiClock (spiClock), .reset (reset), .bus (bus1));

  int checks   = 0;
  int failures = 0;
  logic [47:0] sb_q [$];

  typedef struct {
    logic        sel;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  crcb;  // CRC7 byte including the end bit
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit sel, input logic st, input logic [5:0] idx, input logic [31:0] arg);
    if (sel) begin
      bus1.start = st; bus1.cmdIndex = idx; bus1.argument = arg;
    end else begin
      bus0.start = st; bus0.cmdIndex = idx; bus0.argument = arg;
    end
  endtask

  task automatic get(input bit sel, output logic b, output logic bz, output logic f);
    b  = sel ? bus1.bitOut : bus0.bitOut;
    bz = sel ? bus1.busy   : bus0.busy;
    f  = sel ? bus1.finish : bus0.finish;
  endtask

  // Issue one command, hold start, capture the line up to finish.
  task automatic send(input bit sel, input logic [5:0] idx, input logic [31:0] arg,
                      input logic [7:0] crcb);
    int pre;
    int fin;
    logic [47:0] got, exp;
    bit pre_ok, busy_ok;
    logic b, bz, f;
    pre = sel ? 0 : 8;
    fin = -1;
    got = '0;
    pre_ok = 1'b1;
    busy_ok = 1'b1;
    sb_q.push_back({2'b01, idx, arg, crcb});
    @(negedge spiClock);
    set_req(sel, 1'b1, idx, arg);
    @(posedge spiClock); #1;
    get(sel, b, bz, f);
    if (!(b === 1'b1 && bz === 1'b1 && f === 1'b0)) busy_ok = 1'b0;
    set_req(sel, 1'b1, 6'($urandom), $urandom);  // must be ignored
    for (int k = 1; k <= pre + 60; k++) begin
      @(posedge spiClock); #1;
      get(sel, b, bz, f);
      if (k <= pre) begin
        if (b !== 1'b1) pre_ok = 1'b0;
      end else if (k <= pre + 48) got = {got[46:0], b};
      if (f === 1'b1) begin
        if (bz !== 1'b0) busy_ok = 1'b0;
        fin = k;
        break;
      end else if (bz !== 1'b1) busy_ok = 1'b0;
    end
    exp = sb_q.pop_front();
    if (pre > 0) chk("preamble_ones", 64'(pre_ok), 64'd1);
    chk("frame", 64'(got), 64'(exp));
    chk("finish_edge", 64'(fin), 64'(pre + 49));
    chk("busy_window", 64'(busy_ok), 64'd1);
  endtask

  // Drop start after finish; finish must clear on the next edge.
  task automatic release_req(input bit sel);
    logic b, bz, f;
    @(negedge spiClock);
    set_req(sel, 1'b0, '0, '0);
    @(posedge spiClock); #1;
    get(sel, b, bz, f);
    chk("release_idle", 64'({b, bz, f}), 64'(3'b100));
  endtask

  initial begin
    logic b, bz, f;
    bit ok;

    vecs[0] = '{1'b0, CMD0,   32'h0000_0000, 8'h95};
    vecs[1] = '{1'b0, CMD8,   32'h0000_01AA, 8'h87};
    vecs[2] = '{1'b0, CMD17,  32'h0000_0000, 8'h55};
    vecs[3] = '{1'b0, ACMD41, 32'h4000_0000, 8'h77};
    vecs[4] = '{1'b1, CMD55,  32'h0000_0000, 8'h65};
    vecs[5] = '{1'b1, CMD0,   32'h0000_0000, 8'h95};

    reset = 1'b1;
    set_req(1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0);
    #12;
    get(1'b0, b, bz, f);
    chk("reset_dut0", 64'({b, bz, f}), 64'(3'b100));
    get(1'b1, b, bz, f);
    chk("reset_dut1", 64'({b, bz, f}), 64'(3'b100));
    @(negedge spiClock);
    reset = 1'b0;

    // Table of known frames on both builds
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].sel, vecs[i].idx, vecs[i].arg, vecs[i].crcb);
      release_req(vecs[i].sel);
    end

    // Handshake: start held long after finish, then drop and re-request
    send(1'b0, CMD8, 32'h0000_01AA, 8'h87);
    ok = 1'b1;
    repeat (20) begin
      @(posedge spiClock); #1;
      get(1'b0, b, bz, f);
      if (!(f === 1'b1 && b === 1'b1 && bz === 1'b0)) ok = 1'b0;
    end
    chk("hold_done", 64'(ok), 64'd1);
    release_req(1'b0);
    send(1'b0, CMD55, 32'h0000_0000, 8'h65);
    release_req(1'b0);

    // Abort at frame bit 20
    @(negedge spiClock);
    set_req(1'b0, 1'b1, CMD17, 32'h1234_5678);
    @(posedge spiClock);
    repeat (8 + 20) @(posedge spiClock);
    @(negedge spiClock);
    set_req(1'b0, 1'b0, '0, '0);
    @(posedge spiClock); #1;
    get(1'b0, b, bz, f);
    chk("abort_idle", 64'({b, bz, f}), 64'(3'b100));
    ok = 1'b1;
    repeat (60) begin
      @(posedge spiClock); #1;
      get(1'b0, b, bz, f);
      if (f !== 1'b0 || bz !== 1'b0 || b !== 1'b1) ok = 1'b0;
    end
    chk("abort_no_finish", 64'(ok), 64'd1);

    // Async reset in the middle of the CRC field
    @(negedge spiClock);
    set_req(1'b0, 1'b1, CMD17, 32'h0000_0000);
    @(posedge spiClock);
    repeat (8 + 44) @(posedge spiClock);
    #3 reset = 1'b1;
    #1;
    get(1'b0, b, bz, f);
    chk("async_reset", 64'({b, bz, f}), 64'(3'b100));
    @(negedge spiClock);
    reset = 1'b0;
    set_req(1'b0, 1'b0, '0, '0);
    send(1'b0, CMD17, 32'h0000_0000, 8'h55);
    release_req(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
